pwm_duty_decoder: RTL and testbench

//  Receive side of the PWM link: samples an external PWM waveform, measures

---
 rtl/pwm_duty_decoder_pkg.sv | 19 +
 rtl/pwm_duty_quant.sv | 92 +++++++++
 rtl/pwm_duty_decoder.sv | 126 ++++++++++++
 tb/tb_pwm_duty_decoder.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/pwm_duty_decoder_pkg.sv
// Shared definitions for the PWM receive path.
//   DUTY_W      width of the duty code (0..10 in 10% steps)
//   DUTY_MAX    code for 100% duty
//   NOM_PERIOD  nominal source period in clk cycles (10 us @ 100 MHz)
//   quant_state_e  states of the sequential round-divide in pwm_duty_quant
package pwm_duty_decoder_pkg;

  localparam int                  DUTY_W     = 4;
  localparam logic [DUTY_W-1:0]   DUTY_MAX   = 4'd10;
  localparam int                  NOM_PERIOD = 1000;

  typedef enum logic [1:0] {
    Q_IDLE,
    Q_LOAD,
    Q_STEP,
    Q_DONE
  } quant_state_e;

endpackage

// File: rtl/pwm_duty_quant.sv
// Sequential round-divide: code = min(10, round-half-up(10*H/P)).
// Computed as floor((20*H + P) / (2*P)) by repeated subtraction-free
// comparison: acc walks 2P, 4P, ... and k counts how many multiples fit.
// One comparison per cycle, at most 10 steps, so the result is ready well
// inside the shortest legal period.
// Ports:
//   clk, reset  clock and asynchronous active-high reset (aborts a division)
//   start       1-cycle request; ignored unless idle
//   high        measured high time H (cycles)
//   period      measured period P (cycles)
//   done        1-cycle pulse while the result is presented
//   code        quantized duty 0..10, valid while done is high
module pwm_duty_quant
  import pwm_duty_decoder_pkg::*;
#(
  parameter int CNT_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  high,
  input  logic [CNT_W-1:0]  period,
  output logic              done,
  output logic [DUTY_W-1:0] code
);

  // 20*H + P needs 5 extra bits over the counter width.
  localparam int NUM_W = CNT_W + 5;

  // Numerator of the rounded ratio: adding P before dividing by 2P
  // turns the floor into round-half-up.
  function automatic logic [NUM_W-1:0] round_num(input logic [CNT_W-1:0] h,
                                                  input logic [CNT_W-1:0] p);
    round_num = (NUM_W'(h) << 4) + (NUM_W'(h) << 2) + NUM_W'(p);
  endfunction

  quant_state_e       state, state_nx;
  logic [CNT_W-1:0]   h_q, p_q;
  logic [NUM_W-1:0]   num, acc;
  logic [DUTY_W-1:0]  k;
  logic               step_go;

  // Clamping at DUTY_MAX covers H >= P (glitchy or >100% measurements).
  assign step_go = (num >= acc) && (k < DUTY_MAX);
  assign done    = (state == Q_DONE);
  assign code    = k;

  always_comb begin
    state_nx = state;
    case (state)
      Q_IDLE:  if (start) state_nx = Q_LOAD;
      Q_LOAD:  state_nx = Q_STEP;
      Q_STEP:  if (!step_go) state_nx = Q_DONE;
      Q_DONE:  state_nx = Q_IDLE;
      default: state_nx = Q_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= Q_IDLE;
      h_q   <= '0;
      p_q   <= '0;
      num   <= '0;
      acc   <= '0;
      k     <= '0;
    end else begin
      state <= state_nx;
      case (state)
        Q_IDLE: begin
          if (start) begin
            h_q <= high;
            p_q <= period;
          end
        end
        Q_LOAD: begin
          num <= round_num(h_q, p_q);
          acc <= NUM_W'({p_q, 1'b0});
          k   <= '0;
        end
        Q_STEP: begin
          if (step_go) begin
            acc <= acc + NUM_W'({p_q, 1'b0});
            k   <= k + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/pwm_duty_decoder.sv
// Receive side of the PWM link. Synchronizes an external PWM waveform,
// measures period and high time between rising edges, and quantizes the
// duty cycle to the same 0..10 code the PWM generator accepts.
// Ports:
//   clk         system clock
//   reset       asynchronous active-high reset, clears all state
//   pwm_in      asynchronous PWM input from the pin
//   duty_code   decoded duty 0..10, holds the last result
//   duty_valid  1-cycle pulse when duty_code/period_out/high_out update
//   period_out  last measured period in cycles (0 after a static-level decode)
//   high_out    last measured high time in cycles (0 after a static-level decode)
//   period_err  1-cycle pulse when a period shorter than MIN_PERIOD is seen
module pwm_duty_decoder
  import pwm_duty_decoder_pkg::*;
#(
  parameter int CNT_W      = 12,
  parameter int MIN_PERIOD = 16,
  parameter int TIMEOUT    = 2047
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pwm_in,
  output logic [DUTY_W-1:0] duty_code,
  output logic              duty_valid,
  output logic [CNT_W-1:0]  period_out,
  output logic [CNT_W-1:0]  high_out,
  output logic              period_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] MIN_P   = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0] TO_CNT  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic              pwm_meta, pwm_s, pwm_d;
  logic              rise;
  logic [CNT_W-1:0]  cnt_per, cnt_hi;
  logic              armed;
  logic [CNT_W-1:0]  cap_per;
  logic              short_per;
  logic              q_start;
  logic              timeout_hit;
  logic [CNT_W-1:0]  meas_per, meas_hi;
  logic              q_done;
  logic [DUTY_W-1:0] q_code;

  // Pre-update counter values describe the period that just ended. While
  // armed, timeout keeps cnt_per below 2^CNT_W-1, so +1 cannot wrap.
  assign rise        = pwm_s & ~pwm_d;
  assign cap_per     = cnt_per + 1'b1;
  assign short_per   = (cap_per < MIN_P);
  assign q_start     = rise & armed & ~short_per;
  // cnt_per passes TIMEOUT exactly once per edge-free stretch, so the
  // static-level decode fires once; a coincident rise takes precedence.
  assign timeout_hit = (cnt_per == TO_CNT) & ~rise;

  pwm_duty_quant #(
    .CNT_W (CNT_W)
  ) u_quant (
    .clk    (clk),
    .reset  (reset),
    .start  (q_start),
    .high   (cnt_hi),
    .period (cap_per),
    .done   (q_done),
    .code   (q_code)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_meta   <= 1'b0;
      pwm_s      <= 1'b0;
      pwm_d      <= 1'b0;
      cnt_per    <= '0;
      cnt_hi     <= '0;
      armed      <= 1'b0;
      meas_per   <= '0;
      meas_hi    <= '0;
      period_err <= 1'b0;
      duty_valid <= 1'b0;
      duty_code  <= '0;
      period_out <= '0;
      high_out   <= '0;
    end else begin
      // Synchronizer and edge-detect stage
      pwm_meta <= pwm_in;
      pwm_s    <= pwm_meta;
      pwm_d    <= pwm_s;

      // Measurement stage: the rise cycle itself is the first high cycle
      if (rise) begin
        cnt_per <= '0;
        cnt_hi  <= CNT_ONE;
      end else begin
        if (cnt_per != CNT_MAX) cnt_per <= cnt_per + 1'b1;
        if (pwm_s && (cnt_hi != CNT_MAX)) cnt_hi <= cnt_hi + 1'b1;
      end

      if (rise)             armed <= 1'b1;
      else if (timeout_hit) armed <= 1'b0;

      period_err <= rise & armed & short_per;

      // The quantizer only sees H/P at start; keep them for the result.
      if (q_start) begin
        meas_per <= cap_per;
        meas_hi  <= cnt_hi;
      end

      // Result stage
      duty_valid <= 1'b0;
      if (q_done) begin
        duty_code  <= q_code;
        period_out <= meas_per;
        high_out   <= meas_hi;
        duty_valid <= 1'b1;
      end else if (timeout_hit) begin
        duty_code  <= pwm_s ? DUTY_MAX : '0;
        period_out <= '0;
        high_out   <= '0;
        duty_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pwm_duty_decoder.sv
module tb_pwm_duty_decoder;
  import pwm_duty_decoder_pkg::*;

  localparam int CNT_W = 12;
  // Pin edge to duty_valid: 2 synchronizer flops + edge register, then
  // capture edge + up to 13 cycles of quantization.
  localparam int LAT_MIN  = 6;
  localparam int LAT_MAX  = 16;
  // Pin edge to static-level decode: 3 cycles to the capture edge,
  // 2047 counts, 1 output register.
  localparam int TO_LAT   = 2051;

  logic              clk;
  logic              reset;
  logic              pwm_in;
  logic [DUTY_W-1:0] duty_code;
  logic              duty_valid;
  logic [CNT_W-1:0]  period_out;
  logic [CNT_W-1:0]  high_out;
  logic              period_err;

  pwm_duty_decoder #(
    .CNT_W      (CNT_W),
    .MIN_PERIOD (16),
    .TIMEOUT    (2047)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pwm_in     (pwm_in),
    .duty_code  (duty_code),
    .duty_valid (duty_valid),
    .period_out (period_out),
    .high_out   (high_out),
    .period_err (period_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string name;
    int    code;
    int    per;
    int    hi;
    int    t_lo;
    int    t_hi;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_chk     = 0;
  int   n_err     = 0;
  int   cyc       = 0;
  int   err_seen  = 0;
  int   exp_err   = 0;
  int   last_rise = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp_v);
    n_chk++;
    if (act != exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
    end
  endtask

  task automatic push_exp(input string name, input int code, input int per,
                          input int hi, input int t_lo, input int t_hi);
    exp_t e;
    e.name = name; e.code = code; e.per = per; e.hi = hi;
    e.t_lo = t_lo; e.t_hi = t_hi;
    sb.push_back(e);
  endtask

  // One PWM period at the pin: h cycles high, p-h low. The rise that starts
  // it completes the previous period, so that is where its result is queued.
  task automatic run_period(input int h, input int p, input bit chk,
                            input string name, input int code, input int per,
                            input int hi);
    for (int i = 0; i < p; i++) begin
      @(negedge clk);
      pwm_in = (i < h);
      if (i == 0) begin
        last_rise = cyc;
        if (chk) push_exp(name, code, per, hi, cyc + LAT_MIN, cyc + LAT_MAX);
      end
    end
  endtask

  task automatic check_outputs(input string tag, input int code, input int per,
                               input int hi);
    check({tag, "_code"},   int'(duty_code),  code);
    check({tag, "_period"}, int'(period_out), per);
    check({tag, "_high"},   int'(high_out),   hi);
  endtask

  // Monitor: every duty_valid pops one expectation and checks it.
  always @(negedge clk) begin
    if (period_err) err_seen++;
    if (duty_valid) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected_valid: code=%0d period=%0d high=%0d at cycle %0d, expected no valid",
                 duty_code, period_out, high_out, cyc);
      end else begin
        mon_e = sb.pop_front();
        check({mon_e.name, "_code"},   int'(duty_code),  mon_e.code);
        check({mon_e.name, "_period"}, int'(period_out), mon_e.per);
        check({mon_e.name, "_high"},   int'(high_out),   mon_e.hi);
        n_chk++;
        if (cyc < mon_e.t_lo || cyc > mon_e.t_hi) begin
          n_err++;
          $display("FAIL %s_latency: valid at cycle %0d, expected cycle %0d..%0d",
                   mon_e.name, cyc, mon_e.t_lo, mon_e.t_hi);
        end
      end
    end
  end

  initial begin
    int c;
    reset  = 1'b1;
    pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_outputs("reset", 0, 0, 0);
    check("reset_valid", int'(duty_valid), 0);
    check("reset_perr",  int'(period_err), 0);

    // Nominal period: first rise only arms, then 50% and the sweep.
    run_period(500, NOM_PERIOD, 1'b0, "arm",     0, 0, 0);
    run_period(102, NOM_PERIOD, 1'b1, "duty50",  5, NOM_PERIOD, 500);
    run_period(205, NOM_PERIOD, 1'b1, "duty10",  1, NOM_PERIOD, 102);
    run_period(717, NOM_PERIOD, 1'b1, "duty20",  2, NOM_PERIOD, 205);
    run_period(923, NOM_PERIOD, 1'b1, "duty70",  7, NOM_PERIOD, 717);
    // Rounding at P=100.
    run_period(55,  100,        1'b1, "duty90",  9, NOM_PERIOD, 923);
    run_period(54,  100,        1'b1, "rnd55",   6, 100, 55);
    run_period(99,  100,        1'b1, "rnd54",   5, 100, 54);
    run_period(4,   8,          1'b1, "rnd99",  10, 100, 99);

    // Short period: error pulse, no valid, outputs hold the last result.
    exp_err++;
    run_period(50,  100,        1'b0, "short",   0, 0, 0);
    check_outputs("short_hold", 10, 100, 99);
    check("short_perr_count", err_seen, exp_err);

    // Static low after the last rise: one code-0 decode at timeout.
    run_period(30,  100,        1'b1, "after_short", 5, 100, 50);
    push_exp("static_low", 0, 0, 0, last_rise + TO_LAT, last_rise + TO_LAT);
    repeat (2950) @(negedge clk);

    // Static high: the rise only arms (timeout disarmed), then code 10.
    @(negedge clk);
    pwm_in = 1'b1;
    c = cyc;
    push_exp("static_high", 10, 0, 0, c + TO_LAT, c + TO_LAT);
    repeat (2999) @(negedge clk);
    pwm_in = 1'b0;
    repeat (50) @(negedge clk);

    // Next rise only re-arms; the one after measures.
    run_period(50,  100,        1'b0, "rearm",   0, 0, 0);
    run_period(99,  100,        1'b1, "rearm50", 5, 100, 50);

    // Reset while a 99/100 measurement is mid-STEP: no valid, all zero.
    @(negedge clk);
    pwm_in = 1'b1;
    repeat (8) @(negedge clk);
    reset  = 1'b1;
    pwm_in = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_outputs("midreset", 0, 0, 0);
    check("midreset_valid", int'(duty_valid), 0);

    run_period(50,  100,        1'b0, "post_arm", 0, 0, 0);
    run_period(20,  100,        1'b1, "post50",   5, 100, 50);
    repeat (40) @(negedge clk);

    check("scoreboard_drained", sb.size(), 0);
    check("period_err_total", err_seen, exp_err);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
